// File: rtl/uart_rx_if.sv
// Serial line, oversample tick and received-word bundle for uart_rx.
// The master drives the line and tick; the slave returns the received word.
interface uart_rx_if #(
  parameter int NB_DATA = 8
);
  logic               i_rx;
  logic               i_stick;
  logic [NB_DATA-1:0] o_data;
  logic               o_rx_done;
  logic               o_frame_err;

  modport master (
    output i_rx,
    output i_stick,
    input  o_data,
    input  o_rx_done,
    input  o_frame_err
  );

  modport slave (
    input  i_rx,
    input  i_stick,
    output o_data,
    output o_rx_done,
    output o_frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver: 1 start, NB_DATA data bits LSB first, 1 stop.
// Delivers each word with a one-clock done pulse and a framing-error flag.
module uart_rx #(
  parameter int NB_DATA   = 8,
  parameter int NB_TCOUNT = 4
) (
  input  logic     clk,
  input  logic     i_rst_n,
  uart_rx_if.slave bus
);

  localparam int NB_BCOUNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [NB_TCOUNT-1:0] TMID  =
    NB_TCOUNT'((1 << (NB_TCOUNT - 1)) - 1);
  localparam logic [NB_TCOUNT-1:0] TLAST = '1;
  localparam logic [NB_TCOUNT-1:0] TONE  = NB_TCOUNT'(1);
  localparam logic [NB_BCOUNT-1:0] BLAST = NB_BCOUNT'(NB_DATA - 1);
  localparam logic [NB_BCOUNT-1:0] BONE  = NB_BCOUNT'(1);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_START = 5'b00010,
    S_DATA  = 5'b00100,
    S_STOP  = 5'b01000,
    S_BREAK = 5'b10000
  } state_t;

  state_t               r_state;
  logic [NB_TCOUNT-1:0] r_tick;
  logic [NB_BCOUNT-1:0] r_bit;
  logic [NB_DATA-1:0]   r_shift;
  logic [NB_DATA-1:0]   r_data;
  logic                 r_done;
  logic                 r_ferr;
  logic                 r_rx_meta;
  logic                 r_rx_s;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Frame FSM: samples mid-bit, returns to IDLE at mid-stop.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_tick  <= '0;
          end
        end
        S_START: begin
          if (bus.i_stick) begin
            if (r_tick == TMID) begin
              r_tick <= '0;
              if (!r_rx_s) begin
                r_state <= S_DATA;
                r_bit   <= '0;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_tick <= r_tick + TONE;
            end
          end
        end
        S_DATA: begin
          if (bus.i_stick) begin
            if (r_tick == TLAST) begin
              r_shift <= {r_rx_s, r_shift[NB_DATA-1:1]};
              r_tick  <= '0;
              if (r_bit == BLAST) begin
                r_state <= S_STOP;
              end else begin
                r_bit <= r_bit + BONE;
              end
            end else begin
              r_tick <= r_tick + TONE;
            end
          end
        end
        S_STOP: begin
          if (bus.i_stick) begin
            if (r_tick == TLAST) begin
              r_data  <= r_shift;
              r_ferr  <= ~r_rx_s;
              r_done  <= 1'b1;
              r_tick  <= '0;
              r_state <= r_rx_s ? S_IDLE : S_BREAK;
            end else begin
              r_tick <= r_tick + TONE;
            end
          end
        end
        S_BREAK: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tick  <= '0;
          r_bit   <= '0;
        end
      endcase
    end
  end

  assign bus.o_data      = r_data;
  assign bus.o_rx_done   = r_done;
  assign bus.o_frame_err = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serialises frames at 16 ticks/bit
// and compares delivered words against a queue of expected frames.
module tb_uart_rx;

  logic clk;
  logic rst_n;

  uart_rx_if #(.NB_DATA(8)) bus();

  uart_rx #(
    .NB_DATA  (8),
    .NB_TCOUNT(4)
  ) dut (
    .clk    (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int sdiv     = 1;
  int sphase   = 0;
  int t_start  = 0;
  int t_done   = 0;
  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Oversample tick: one pulse every sdiv clocks.
  always @(posedge clk) begin
    #1;
    if (sphase >= sdiv - 1) begin
      sphase = 0;
      bus.i_stick = 1'b1;
    end else begin
      sphase = sphase + 1;
      bus.i_stick = 1'b0;
    end
  end

  // Capture every delivered word as {frame_err, data}.
  always @(negedge clk) begin
    if (bus.o_rx_done === 1'b1) begin
      obs_q.push_back({bus.o_frame_err, bus.o_data});
      t_done = cyc;
    end
  end

  task automatic clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    bus.i_rx = b;
    clks(16 * sdiv);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    bus.i_rx = 1'b0;
    t_start = cyc;
    clks(16 * sdiv);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.i_rx = 1'b1;
    clks(4);
    n_checks++;
    if (bus.o_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data got %h want 00", bus.o_data);
    end
    n_checks++;
    if (bus.o_rx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done got %b want 0", bus.o_rx_done);
    end
    n_checks++;
    if (bus.o_frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ferr got %b want 0", bus.o_frame_err);
    end
    rst_n = 1'b1;
    clks(20);
  endtask

  task automatic test_basic;
    int lat;
    obs_q.delete();
    send_frame(8'hA5, 1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL basic_count got %0d want 1", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0] !== {1'b0, 8'hA5}) begin
        n_fail++;
        $display("FAIL basic_word got %h want %h", obs_q[0], {1'b0, 8'hA5});
      end
    end
    lat = t_done - t_start;
    n_checks++;
    if (lat < 152 || lat > 159) begin
      n_fail++;
      $display("FAIL basic_latency got %0d want 152..159", lat);
    end
  endtask

  task automatic test_glitch;
    obs_q.delete();
    bus.i_rx = 1'b0;
    clks(4 * sdiv);
    bus.i_rx = 1'b1;
    clks(32 * sdiv);
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL glitch_nodone got %0d want 0", obs_q.size());
    end
    send_frame(8'h11, 1'b1);
    send_bit(1'b1);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b0, 8'h11}) begin
      n_fail++;
      $display("FAIL glitch_after got n=%0d w=%h want n=1 w=011",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 9'h0);
    end
  endtask

  task automatic test_break;
    obs_q.delete();
    send_frame(8'h3C, 1'b0);
    for (int i = 0; i < 40; i++) send_bit(1'b0);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b1, 8'h3C}) begin
      n_fail++;
      $display("FAIL break_word got n=%0d w=%h want n=1 w=13c",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 9'h0);
    end
    send_bit(1'b1);
    send_bit(1'b1);
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL break_extra got %0d want 1", obs_q.size());
    end
    send_frame(8'h7E, 1'b1);
    send_bit(1'b1);
    n_checks++;
    if (obs_q.size() != 2 || obs_q[obs_q.size()-1] !== {1'b0, 8'h7E}) begin
      n_fail++;
      $display("FAIL break_recover got n=%0d w=%h want n=2 w=07e",
               obs_q.size(), obs_q[obs_q.size()-1]);
    end
  endtask

  task automatic test_back_to_back;
    obs_q.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_bit(1'b1);
    n_checks++;
    if (obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count got %0d want 2", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0] !== 9'h000 || obs_q[1] !== {1'b0, 8'hFF}) begin
        n_fail++;
        $display("FAIL b2b_words got %h %h want 000 0ff",
                 obs_q[0], obs_q[1]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    d = 8'h5A;
    obs_q.delete();
    bus.i_rx = 1'b0;
    clks(16 * sdiv);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    bus.i_rx = d[3];
    clks(8 * sdiv);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_data !== 8'h00 || bus.o_rx_done !== 1'b0 ||
        bus.o_frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got d=%h done=%b err=%b want 00 0 0",
               bus.o_data, bus.o_rx_done, bus.o_frame_err);
    end
    bus.i_rx = 1'b1;
    clks(5);
    rst_n = 1'b1;
    clks(32 * sdiv);
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_nodone got %0d want 0", obs_q.size());
    end
    send_frame(d, 1'b1);
    send_bit(1'b1);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b0, d}) begin
      n_fail++;
      $display("FAIL rstmid_after got n=%0d w=%h want n=1 w=05a",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 9'h0);
    end
  endtask

  task automatic test_slow_tick;
    int lat;
    sdiv = 4;
    clks(16);
    obs_q.delete();
    send_frame(8'hC3, 1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b0, 8'hC3}) begin
      n_fail++;
      $display("FAIL slow_word got n=%0d w=%h want n=1 w=0c3",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 9'h0);
    end
    lat = t_done - t_start;
    n_checks++;
    if (lat < 608 || lat > 618) begin
      n_fail++;
      $display("FAIL slow_latency got %0d want 608..618", lat);
    end
    sdiv = 1;
    clks(16);
  endtask

  task automatic test_random;
    logic [7:0] d;
    logic       stop;
    int         extra;
    obs_q.delete();
    exp_q.delete();
    for (int f = 0; f < 12; f++) begin
      d     = 8'($urandom_range(0, 255));
      stop  = ($urandom_range(0, 3) != 0);
      exp_q.push_back({~stop, d});
      send_frame(d, stop);
      if (!stop) begin
        extra = $urandom_range(0, 3);
        for (int i = 0; i < extra; i++) send_bit(1'b0);
        send_bit(1'b1);
      end else begin
        extra = $urandom_range(0, 1);
        for (int i = 0; i < extra; i++) send_bit(1'b1);
      end
    end
    send_bit(1'b1);
    send_bit(1'b1);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count got %0d want %0d",
               obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand_word[%0d] got %h want %h",
                   i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    bus.i_rx    = 1'b1;
    bus.i_stick = 1'b0;
    rst_n       = 1'b0;
    test_reset;
    test_basic;
    test_glitch;
    test_break;
    test_back_to_back;
    test_reset_mid;
    test_slow_tick;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
